vga_scanout: RTL and testbench

Video scan-out engine for the SoC display path. Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock and issues one framebuffer read address per pixel to the synchronous-read port of the 64 KiB video RAM. It realigns sync and blanking to the RAM read latency and drives the 3-bit RGB pins. It also gives the CPU side a once-per-frame vertical-blank pulse and a frame counter, so software can update the framebuffer tear-free.

---
 rtl/vga_scanout.sv | 126 ++++++++++++
 tb/tb_vga_scanout.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out engine: 640x480@60 timing, framebuffer address generation,
// sync/blank realignment to RAM read latency, and a CPU-side frame event.
module vga_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display_en,
  output logic [15:0] fb_addr,
  input  logic [7:0]  fb_data,
  output logic [2:0]  vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vblank_pulse,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 10/9 bits so the address slices always exist.
  localparam int unsigned HW       = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int unsigned VW       = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_last;
  logic          v_last;
  logic          frame_end;
  logic          active_s0;
  logic          hs_n_s0;
  logic          vs_n_s0;

  logic [RAM_LATENCY-1:0] active_q;
  logic [RAM_LATENCY-1:0] hs_n_q;
  logic [RAM_LATENCY-1:0] vs_n_q;
  logic [RAM_LATENCY-1:0] en_q;

  logic fb_data_unused;

  assign h_last    = (hcnt == HW'(H_TOTAL - 1));
  assign v_last    = (vcnt == VW'(V_TOTAL - 1));
  // Last pixel of the last active line: next stage-0 state is (0, V_ACTIVE).
  assign frame_end = h_last && (vcnt == VW'(V_ACTIVE - 1));

  assign active_s0 = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hs_n_s0   = !((hcnt >= HW'(HS_START)) && (hcnt <= HW'(HS_END)));
  assign vs_n_s0   = !((vcnt >= VW'(VS_START)) && (vcnt <= VW'(VS_END)));

  // 160x120 framebuffer with 4x4 pixel replication; also driven in blanking.
  assign fb_addr = {1'b0, vcnt[8:2], hcnt[9:2]};

  assign fb_data_unused = ^fb_data[7:3];

  // Stage-0 pixel/line counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Delay line aligning blank, syncs and enable with fb_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      hs_n_q   <= '1;
      vs_n_q   <= '1;
      en_q     <= '0;
    end else begin
      active_q[0] <= active_s0;
      hs_n_q[0]   <= hs_n_s0;
      vs_n_q[0]   <= vs_n_s0;
      en_q[0]     <= display_en;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        active_q[i] <= active_q[i-1];
        hs_n_q[i]   <= hs_n_q[i-1];
        vs_n_q[i]   <= vs_n_q[i-1];
        en_q[i]     <= en_q[i-1];
      end
    end
  end

  // Output register, one stage after the delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_rgb   <= 3'b000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_rgb   <= (active_q[RAM_LATENCY-1] && en_q[RAM_LATENCY-1]) ? fb_data[2:0] : 3'b000;
      vga_hsync <= hs_n_q[RAM_LATENCY-1];
      vga_vsync <= vs_n_q[RAM_LATENCY-1];
    end
  end

  // CPU-side frame event, coincident with stage-0 (0, V_ACTIVE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_pulse <= 1'b0;
      frame_count  <= 16'h0000;
    end else begin
      vblank_pulse <= frame_end;
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a default 640x480 instance (latency 1) and a
// scaled-down instance (latency 3) for frame-level timing.
module tb_vga_scanout;

  logic        clk;
  logic        reset;
  logic        display_en;
  logic        rnd_mode;
  logic        white_a;
  logic [7:0]  rnd_byte;

  logic [15:0] fb_addr_a, fb_addr_b;
  logic [7:0]  fb_data_a, fb_data_b;
  logic [7:0]  ram_a_q, ram_b1, ram_b2, ram_b3;
  logic [2:0]  rgb_a, rgb_b;
  logic        hs_a, vs_a, hs_b, vs_b;
  logic        vbp_a, vbp_b;
  logic [15:0] fc_a, fc_b;

  int checks;
  int errors;

  vga_scanout #(.RAM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .display_en(display_en),
    .fb_addr(fb_addr_a), .fb_data(fb_data_a),
    .vga_rgb(rgb_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
    .vblank_pulse(vbp_a), .frame_count(fc_a)
  );

  // 32 x 15 total, 16 x 8 active, hsync at 20..27, vsync at lines 10..11.
  vga_scanout #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .RAM_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(reset), .display_en(1'b1),
    .fb_addr(fb_addr_b), .fb_data(fb_data_b),
    .vga_rgb(rgb_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
    .vblank_pulse(vbp_b), .frame_count(fc_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // RAM models: data = address low byte (or white), latency 1 and 3.
  always @(posedge clk) begin
    rnd_byte <= 8'($urandom);
    ram_a_q  <= white_a ? 8'hFF : fb_addr_a[7:0];
    ram_b1   <= fb_addr_b[7:0];
    ram_b2   <= ram_b1;
    ram_b3   <= ram_b2;
  end
  assign fb_data_a = rnd_mode ? rnd_byte : ram_a_q;
  assign fb_data_b = rnd_mode ? rnd_byte : ram_b3;

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench on the negedge of release: stage 0 is (0,0), n = 0.
  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    rnd_mode = 1'b1;
    reset = 1'b0;
    repeat (5) step();
    checks += 8;
    if (rgb_a !== 3'b000) begin errors++; $display("FAIL reset_rgb_a: got %0d want 0", rgb_a); end
    if (hs_a !== 1'b1) begin errors++; $display("FAIL reset_hsync_a: got %b want 1", hs_a); end
    if (vs_a !== 1'b1) begin errors++; $display("FAIL reset_vsync_a: got %b want 1", vs_a); end
    if (fb_addr_a !== 16'h0000) begin errors++; $display("FAIL reset_addr_a: got %h want 0000", fb_addr_a); end
    if (fc_a !== 16'h0000) begin errors++; $display("FAIL reset_fc_a: got %h want 0000", fc_a); end
    if (vbp_a !== 1'b0) begin errors++; $display("FAIL reset_vblank_a: got %b want 0", vbp_a); end
    if (rgb_b !== 3'b000) begin errors++; $display("FAIL reset_rgb_b: got %0d want 0", rgb_b); end
    if (hs_b !== 1'b1) begin errors++; $display("FAIL reset_hsync_b: got %b want 1", hs_b); end
    reset = 1'b1;
    rnd_mode = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (fb_addr_a !== ((n < 4) ? 16'h0000 : 16'h0001)) begin
        errors++;
        $display("FAIL release_addr n=%0d: got %h want %h", n, fb_addr_a, (n < 4) ? 16'h0000 : 16'h0001);
      end
      step();
    end
  endtask

  task automatic test_horizontal();
    int first_fall, rise, second_fall, bad;
    logic prev;
    first_fall = -1; rise = -1; second_fall = -1; bad = 0; prev = 1'b1;
    do_reset();
    for (int n = 0; n <= 1700; n++) begin
      if (prev && !hs_a) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
      end
      if (!prev && hs_a && rise < 0) rise = n;
      if (n >= 2 && ((n - 2) % 800) >= 640 && rgb_a !== 3'b000) bad++;
      prev = hs_a;
      step();
    end
    checks += 4;
    if (first_fall != 658) begin errors++; $display("FAIL hsync_first_fall: got %0d want 658", first_fall); end
    if (rise - first_fall != 96) begin errors++; $display("FAIL hsync_width: got %0d want 96", rise - first_fall); end
    if (second_fall - first_fall != 800) begin errors++; $display("FAIL hsync_period: got %0d want 800", second_fall - first_fall); end
    if (bad != 0) begin errors++; $display("FAIL hblank_rgb: got %0d nonzero pixels want 0", bad); end
  endtask

  task automatic test_alignment();
    do_reset();
    repeat (3038) step();             // stage (638, 3)
    checks++;
    if (fb_addr_a !== 16'h009F) begin errors++; $display("FAIL addr_638_3: got %h want 009F", fb_addr_a); end
    repeat (2) step();
    checks++;
    if (rgb_a !== 3'b111) begin errors++; $display("FAIL rgb_638_3: got %0d want 7", rgb_a); end
    repeat (14) step();               // output of stage (652, 3), data would be 3
    checks++;
    if (rgb_a !== 3'b000) begin errors++; $display("FAIL rgb_blank_652: got %0d want 0", rgb_a); end
    repeat (4813 - 3054) step();      // stage (13, 6)
    checks++;
    if (fb_addr_a !== 16'h0103) begin errors++; $display("FAIL addr_13_6: got %h want 0103", fb_addr_a); end
    repeat (2) step();
    checks++;
    if (rgb_a !== 3'b011) begin errors++; $display("FAIL rgb_13_6: got %0d want 3", rgb_a); end
  endtask

  task automatic test_latency3();
    int fall;
    logic prev;
    fall = -1; prev = 1'b1;
    do_reset();
    for (int n = 0; n <= 215; n++) begin
      if (prev && !hs_b && fall < 0) fall = n;
      prev = hs_b;
      if (n == 205) begin
        checks++;
        if (fb_addr_b !== 16'h0103) begin errors++; $display("FAIL lat3_addr: got %h want 0103", fb_addr_b); end
      end
      if (n == 209) begin
        checks++;
        if (rgb_b !== 3'b011) begin errors++; $display("FAIL lat3_rgb: got %0d want 3", rgb_b); end
      end
      if (n == 212) begin
        checks++;
        if (rgb_b !== 3'b000) begin errors++; $display("FAIL lat3_blank: got %0d want 0", rgb_b); end
      end
      step();
    end
    checks++;
    if (fall != 24) begin errors++; $display("FAIL lat3_hsync_fall: got %0d want 24", fall); end
  endtask

  task automatic test_display_en();
    white_a = 1'b1;
    display_en = 1'b1;
    do_reset();
    for (int n = 0; n <= 2260; n++) begin
      if (n == 1701 || n == 1802) begin
        checks++;
        if (rgb_a !== 3'b111) begin errors++; $display("FAIL den_on n=%0d: got %0d want 7", n, rgb_a); end
      end
      if (n == 1702 || n == 1801) begin
        checks++;
        if (rgb_a !== 3'b000) begin errors++; $display("FAIL den_off n=%0d: got %0d want 0", n, rgb_a); end
      end
      if (n == 2257 || n == 2258) begin
        checks++;
        if (hs_a !== ((n == 2257) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL den_hsync n=%0d: got %b want %b", n, hs_a, (n == 2257) ? 1'b1 : 1'b0);
        end
      end
      if (n == 1700) display_en = 1'b0;
      if (n == 1800) display_en = 1'b1;
      step();
    end
    white_a = 1'b0;
  endtask

  task automatic test_vertical();
    int first_fall, rise, second_fall, first_pulse, pulses;
    logic prev;
    first_fall = -1; rise = -1; second_fall = -1; first_pulse = -1; pulses = 0; prev = 1'b1;
    do_reset();
    for (int n = 0; n <= 900; n++) begin
      if (prev && !vs_b) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
      end
      if (!prev && vs_b && rise < 0) rise = n;
      prev = vs_b;
      if (vbp_b === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = n;
      end
      if (n == 735 || n == 736) begin
        checks++;
        if (fc_b !== ((n == 735) ? 16'd1 : 16'd2)) begin
          errors++;
          $display("FAIL frame_count n=%0d: got %0d want %0d", n, fc_b, (n == 735) ? 1 : 2);
        end
      end
      step();
    end
    checks += 5;
    if (first_fall != 324) begin errors++; $display("FAIL vsync_first_fall: got %0d want 324", first_fall); end
    if (rise - first_fall != 64) begin errors++; $display("FAIL vsync_width: got %0d want 64", rise - first_fall); end
    if (second_fall - first_fall != 480) begin errors++; $display("FAIL vsync_period: got %0d want 480", second_fall - first_fall); end
    if (first_pulse != 256) begin errors++; $display("FAIL vblank_first: got %0d want 256", first_pulse); end
    if (pulses != 2) begin errors++; $display("FAIL vblank_count: got %0d want 2", pulses); end
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 1'b0;
    force dut_b.frame_count = 16'hFFFF;
    step();
    release dut_b.frame_count;
    checks++;
    if (fc_b !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want FFFF", fc_b); end
    for (int n = 0; n < 600 && !seen; n++) begin
      step();
      if (vbp_b === 1'b1) seen = 1'b1;
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL wrap_pulse: got none want pulse within 600 cycles"); end
    if (fc_b !== 16'h0000) begin errors++; $display("FAIL wrap_value: got %h want 0000", fc_b); end
  endtask

  task automatic test_reset_mid();
    int fall, first_pulse, pulses;
    logic prev;
    fall = -1; first_pulse = -1; pulses = 0; prev = 1'b1;
    do_reset();
    repeat (3100) step();             // output of stage (698, 3): in hsync
    checks++;
    if (hs_a !== 1'b0) begin errors++; $display("FAIL mid_pre_hsync: got %b want 0", hs_a); end
    reset = 1'b0;
    #1;
    checks += 6;
    if (rgb_a !== 3'b000) begin errors++; $display("FAIL mid_rgb: got %0d want 0", rgb_a); end
    if (hs_a !== 1'b1) begin errors++; $display("FAIL mid_hsync: got %b want 1", hs_a); end
    if (vs_a !== 1'b1) begin errors++; $display("FAIL mid_vsync: got %b want 1", vs_a); end
    if (fb_addr_a !== 16'h0000) begin errors++; $display("FAIL mid_addr: got %h want 0000", fb_addr_a); end
    if (fc_b !== 16'h0000) begin errors++; $display("FAIL mid_fc_b: got %h want 0000", fc_b); end
    if (vbp_b !== 1'b0) begin errors++; $display("FAIL mid_vblank_b: got %b want 0", vbp_b); end
    step();
    reset = 1'b1;
    for (int n = 0; n <= 700; n++) begin
      if (prev && !hs_a && fall < 0) fall = n;
      prev = hs_a;
      if (n <= 300 && vbp_b === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = n;
      end
      if (n == 4) begin
        checks++;
        if (fb_addr_a !== 16'h0001) begin errors++; $display("FAIL mid_release_addr: got %h want 0001", fb_addr_a); end
      end
      if (n == 300) begin
        checks++;
        if (fc_b !== 16'd1) begin errors++; $display("FAIL mid_fc_after: got %0d want 1", fc_b); end
      end
      step();
    end
    checks += 3;
    if (fall != 658) begin errors++; $display("FAIL mid_hsync_fall: got %0d want 658", fall); end
    if (first_pulse != 256) begin errors++; $display("FAIL mid_vblank_first: got %0d want 256", first_pulse); end
    if (pulses != 1) begin errors++; $display("FAIL mid_vblank_count: got %0d want 1", pulses); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    display_en = 1'b1;
    rnd_mode = 1'b1;
    white_a = 1'b0;
    step();
    test_reset();
    test_horizontal();
    test_alignment();
    test_latency3();
    test_display_en();
    test_vertical();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
